// File: rtl/riscv_mem_checker_if.sv
// Memory read port of the riscv self-check block.
//   rd_en    request strobe, driven by the checker
//   rd_addr  data-memory address, driven by the checker
//   rd_data  read data, returned by the memory one cycle after rd_en
// Modports: master = checker side, slave = memory side.
interface riscv_mem_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/riscv_mem_checker.sv
// riscv_mem_checker: synthesizable data-memory self-check block.
// Holds N_CHECKS expected values, each with a trigger cycle, address and
// access size. After start, every active entry is read through the memory
// read port once the run-relative cycle counter reaches its trigger, and the
// returned data is compared under a byte/half/word mask.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tbl_we/tbl_idx/...  table write port (accepted only when not busy)
//   n_checks            active entry count, sampled at start, clamped
//   start               1-cycle pulse arming a run (ignored while busy)
//   mem                 read port (master): rd_en, rd_addr out; rd_data in
//   busy, done          run in progress / run finished (level)
//   pass_cnt, fail_cnt  compare results
//   fail_seen, fail_idx, fail_data  sticky first-failure record
//   halt_req            stop request on first failure
//
// Build option: define CHECKER_STOP_ON_FAIL_EN to end the run at the first
// failing compare and raise halt_req; otherwise halt_req is tied low and all
// active entries are evaluated.
module riscv_mem_checker #(
  parameter int  N_CHECKS = 32,
  parameter int  ADDR_W   = 32,
  parameter int  DATA_W   = 32,
  parameter int  CYC_W    = 16,
  localparam int IDX_W    = $clog2(N_CHECKS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tbl_we,
  input  logic [IDX_W-1:0]    tbl_idx,
  input  logic [CYC_W-1:0]    tbl_cycle,
  input  logic [ADDR_W-1:0]   tbl_addr,
  input  logic [1:0]          tbl_size,
  input  logic [DATA_W-1:0]   tbl_value,
  input  logic [IDX_W:0]      n_checks,
  input  logic                start,
  riscv_mem_checker_if.master mem,
  output logic                busy,
  output logic                done,
  output logic [IDX_W:0]      pass_cnt,
  output logic [IDX_W:0]      fail_cnt,
  output logic                fail_seen,
  output logic [IDX_W-1:0]    fail_idx,
  output logic [DATA_W-1:0]   fail_data,
  output logic                halt_req
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Byte/half/word compare mask; bits above 32 are never compared.
  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
    logic [DATA_W-1:0] m;
    m = '0;
    case (sz)
      2'b00:   m[7:0]  = '1;
      2'b01:   m[15:0] = '1;
      default: m[31:0] = '1;
    endcase
    return m;
  endfunction

  // Run cycle counter sticks at all-ones instead of wrapping.
  function automatic logic [CYC_W-1:0] cyc_sat_inc(input logic [CYC_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [IDX_W:0] clamp_n(input logic [IDX_W:0] n);
    return (n > (IDX_W+1)'(N_CHECKS)) ? (IDX_W+1)'(N_CHECKS) : n;
  endfunction

  // Check table: storage only, never reset.
  logic [CYC_W-1:0]  tbl_cyc_mem  [N_CHECKS];
  logic [ADDR_W-1:0] tbl_addr_mem [N_CHECKS];
  logic [1:0]        tbl_size_mem [N_CHECKS];
  logic [DATA_W-1:0] tbl_val_mem  [N_CHECKS];

  state_t            state;
  logic [CYC_W-1:0]  cyc;
  logic [IDX_W:0]    idx;
  logic [IDX_W:0]    n_lat;

  logic              idle_like;
  logic              accept_start;
  logic [IDX_W-1:0]  ent;
  logic [IDX_W:0]    idx_inc;
  logic              trig;
  logic [DATA_W-1:0] cmp_mask;
  logic [DATA_W-1:0] rd_masked;
  logic              match;
  logic              stop_now;

  assign idle_like    = (state == S_IDLE) || (state == S_DONE);
  assign accept_start = start && idle_like;
  assign ent          = idx[IDX_W-1:0];
  assign idx_inc      = idx + (IDX_W+1)'(1);

  always_ff @(posedge clk) begin
    if (tbl_we && idle_like) begin
      tbl_cyc_mem[tbl_idx]  <= tbl_cycle;
      tbl_addr_mem[tbl_idx] <= tbl_addr;
      tbl_size_mem[tbl_idx] <= tbl_size;
      tbl_val_mem[tbl_idx]  <= tbl_value;
    end
  end

  // Issue stage: request the entry as soon as its trigger cycle is reached.
  assign trig        = (state == S_RUN) && (idx != n_lat) && (cyc >= tbl_cyc_mem[ent]);
  assign mem.rd_en   = trig;
  assign mem.rd_addr = tbl_addr_mem[ent];

  // Compare stage: rd_data belongs to the entry still held in idx.
  assign cmp_mask  = size_mask(tbl_size_mem[ent]);
  assign rd_masked = mem.rd_data & cmp_mask;
  assign match     = (rd_masked == (tbl_val_mem[ent] & cmp_mask));

`ifdef CHECKER_STOP_ON_FAIL_EN
  logic halt_q;

  assign stop_now = (state == S_CMP) && !match;

  always_ff @(posedge clk) begin
    if (rst)               halt_q <= 1'b0;
    else if (accept_start) halt_q <= 1'b0;
    else if (stop_now)     halt_q <= 1'b1;
  end

  assign halt_req = halt_q;
`else
  assign stop_now = 1'b0;
  assign halt_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cyc       <= '0;
      idx       <= '0;
      n_lat     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_data <= '0;
    end else begin
      if ((state == S_RUN) || (state == S_CMP)) cyc <= cyc_sat_inc(cyc);

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            cyc       <= '0;
            idx       <= '0;
            n_lat     <= clamp_n(n_checks);
            busy      <= 1'b1;
            done      <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            fail_idx  <= '0;
            fail_data <= '0;
          end
        end

        S_RUN: begin
          if (idx == n_lat) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (trig) begin
            state <= S_CMP;
          end
        end

        S_CMP: begin
          if (match) begin
            pass_cnt <= pass_cnt + (IDX_W+1)'(1);
          end else begin
            fail_cnt <= fail_cnt + (IDX_W+1)'(1);
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              fail_idx  <= ent;
              fail_data <= rd_masked;
            end
          end
          idx <= idx_inc;
          // Finishing straight from CMP makes done coincide with the last count.
          if ((idx_inc == n_lat) || stop_now) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
